// File: rtl/cnn_operand_loader.sv
// Load/run/collect sequencer feeding the CNN accelerator from a byte stream.
// Optional trailing-checksum frame check enabled by defining CNN_LOADER_CHECKSUM_EN.
module cnn_operand_loader #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned N_IN       = 16,
    parameter int unsigned N_NEU      = 4,
    parameter int unsigned RUN_CYCLES = 20
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Clr,
    input  logic [DATA_W-1:0]             S_Data,
    input  logic                          S_Valid,
    output logic                          S_Ready,
    output logic [N_IN*DATA_W-1:0]        In_Flat,
    output logic [N_NEU*N_IN*DATA_W-1:0]  W_Flat,
    output logic                          Acc_Rst,
    input  logic [2*DATA_W-1:0]           CNN_OUT,
    output logic [2*DATA_W-1:0]           Res_Data,
    output logic                          Res_Valid,
    input  logic                          Res_Ready,
    output logic                          Busy,
    output logic                          Err
);

    localparam int unsigned L = N_IN * (1 + N_NEU);
`ifdef CNN_LOADER_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = L + 1;
`else
    localparam int unsigned FRAME_BYTES = L;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int unsigned RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    typedef enum logic [1:0] {
        StLoad,
        StRun,
        StHold
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RUN_W-1:0]        run_q, run_d;
    logic                    res_valid_q, res_valid_d;
    logic [2*DATA_W-1:0]     res_data_q, res_data_d;
    logic                    slot_we;
    // Operand slots in stream order: inputs first, then weight banks.
    logic [L*DATA_W-1:0]     frame_q;

`ifdef CNN_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]       sum_q, sum_d;
    logic                    err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        slot_we     = 1'b0;
`ifdef CNN_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        err_d       = err_q;
`endif
        if (Clr) begin
            // Clear beats any concurrent beat or result handshake.
            state_d     = StLoad;
            cnt_d       = '0;
            run_d       = '0;
            res_valid_d = 1'b0;
`ifdef CNN_LOADER_CHECKSUM_EN
            sum_d       = '0;
            err_d       = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (S_Valid) begin
                        if (cnt_q < CNT_W'(L)) begin
                            slot_we = 1'b1;
                        end
`ifdef CNN_LOADER_CHECKSUM_EN
                        if (cnt_q == CNT_W'(L)) begin
                            cnt_d = '0;
                            sum_d = '0;
                            // A sticky error blocks every frame until cleared.
                            if (S_Data != sum_q) begin
                                err_d = 1'b1;
                            end else if (!err_q) begin
                                state_d = StRun;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            sum_d = sum_q + S_Data;
                        end
`else
                        if (cnt_q == CNT_W'(L - 1)) begin
                            cnt_d   = '0;
                            state_d = StRun;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
`endif
                    end
                end
                StRun: begin
                    if (run_q == RUN_W'(RUN_CYCLES - 1)) begin
                        run_d       = '0;
                        res_data_d  = CNN_OUT;
                        res_valid_d = 1'b1;
                        state_d     = StHold;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                StHold: begin
                    if (res_valid_q && Res_Ready) begin
                        res_valid_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = StLoad;
                    end
                end
                default: begin
                    state_d = StLoad;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            run_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

`ifdef CNN_LOADER_CHECKSUM_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            frame_q <= '0;
        end else if (slot_we) begin
            for (int unsigned s = 0; s < L; s++) begin
                if (cnt_q == CNT_W'(s)) begin
                    frame_q[DATA_W*s +: DATA_W] <= S_Data;
                end
            end
        end
    end

    assign In_Flat   = frame_q[N_IN*DATA_W-1:0];
    assign W_Flat    = frame_q[L*DATA_W-1:N_IN*DATA_W];
    // Gated with Rst so the handshake and accelerator reset react without a clock.
    assign S_Ready   = Rst && (state_q == StLoad);
    assign Acc_Rst   = !Rst || (state_q != StRun);
    assign Busy      = (state_q == StRun) || (state_q == StHold);
    assign Res_Valid = res_valid_q;
    assign Res_Data  = res_data_q;

endmodule
